// File: rtl/fg_waveform_analyzer.sv
// Periodic trapezoid/triangle/pulse analyzer: period, ON time, slopes and amplitude per period.
// Optional FG_ANALYZER_EDGETIME_EN adds rise_count_o / fall_count_o edge-duration outputs.
module fg_waveform_analyzer #(
  parameter int unsigned COUNTER_BITWIDTH  = 32,
  parameter int unsigned WAVEFORM_BITWIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                clk_en_i,
  input  logic                                clear_i,
  input  logic signed [WAVEFORM_BITWIDTH:0]   sample_i,
  output logic [COUNTER_BITWIDTH-1:0]         period_o,
  output logic [COUNTER_BITWIDTH-1:0]         on_count_o,
  output logic [WAVEFORM_BITWIDTH-1:0]        k_rise_o,
  output logic [WAVEFORM_BITWIDTH-1:0]        k_fall_o,
  output logic [WAVEFORM_BITWIDTH-1:0]        amplitude_o,
`ifdef FG_ANALYZER_EDGETIME_EN
  output logic [COUNTER_BITWIDTH-1:0]         rise_count_o,
  output logic [COUNTER_BITWIDTH-1:0]         fall_count_o,
`endif
  output logic                                valid_o,
  output logic                                busy_o,
  output logic                                error_o
);

  localparam int unsigned W  = WAVEFORM_BITWIDTH;
  localparam int unsigned CW = COUNTER_BITWIDTH;

  typedef enum logic [2:0] {ARM, LOW, RISE, HIGH, FALL} state_t;

  state_t             state, state_next;
  logic signed [W:0]  prev;
  logic [CW-1:0]      cnt, on_sh;
  logic [W-1:0]       kr_sh, kf_sh, amp_sh;
  logic               have_start;
  logic               gt, eq, lt, zero, neg;
  logic               rise_start, fault, sat, abort, commit;
  logic               cap_amp_cur, cap_amp_prev, cap_fall;

  assign gt   = sample_i > prev;
  assign eq   = sample_i == prev;
  assign lt   = sample_i < prev;
  assign zero = sample_i == '0;
  assign neg  = sample_i[W];

  assign busy_o = state != ARM;

  always_comb begin
    state_next   = state;
    rise_start   = 1'b0;
    fault        = 1'b0;
    cap_amp_cur  = 1'b0;
    cap_amp_prev = 1'b0;
    cap_fall     = 1'b0;
    if (neg) begin
      fault      = 1'b1;
      state_next = ARM;
    end else begin
      unique case (state)
        ARM:  if (zero) state_next = LOW;
        LOW:  if (gt) rise_start = 1'b1;
        RISE: begin
          if (eq) begin
            state_next  = HIGH;
            cap_amp_cur = 1'b1;
          end else if (lt) begin
            state_next   = FALL;
            cap_amp_prev = 1'b1;
            cap_fall     = 1'b1;
          end
        end
        HIGH: begin
          if (lt) begin
            state_next = FALL;
            cap_fall   = 1'b1;
          end else if (gt) begin
            fault      = 1'b1;
            state_next = ARM;
          end
        end
        FALL: begin
          if (gt)        rise_start = 1'b1;
          else if (zero) state_next = LOW;
        end
        default: state_next = ARM;
      endcase
    end
    if (rise_start) state_next = RISE;
    // cnt never increments in ARM, so saturation can only hit a live measurement
    sat = !fault && !rise_start && (state != ARM) && (cnt == '1);
    if (sat) state_next = ARM;
    abort  = fault || sat;
    commit = clk_en_i && !clear_i && rise_start && have_start;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ARM;
      prev        <= '0;
      cnt         <= '0;
      have_start  <= 1'b0;
      on_sh       <= '0;
      kr_sh       <= '0;
      kf_sh       <= '0;
      amp_sh      <= '0;
      period_o    <= '0;
      on_count_o  <= '0;
      k_rise_o    <= '0;
      k_fall_o    <= '0;
      amplitude_o <= '0;
      valid_o     <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (clear_i) begin
        state       <= ARM;
        cnt         <= '0;
        have_start  <= 1'b0;
        error_o     <= 1'b0;
        period_o    <= '0;
        on_count_o  <= '0;
        k_rise_o    <= '0;
        k_fall_o    <= '0;
        amplitude_o <= '0;
      end else if (clk_en_i) begin
        state <= state_next;
        prev  <= sample_i;
        if (abort) begin
          error_o    <= 1'b1;
          have_start <= 1'b0;
          cnt        <= '0;
        end else if (rise_start) begin
          if (have_start) begin
            period_o    <= cnt;
            on_count_o  <= on_sh;
            k_rise_o    <= kr_sh;
            k_fall_o    <= kf_sh;
            amplitude_o <= amp_sh;
            valid_o     <= 1'b1;
          end
          cnt        <= CW'(1);
          kr_sh      <= W'({sample_i[W], sample_i} - {prev[W], prev});
          have_start <= 1'b1;
        end else begin
          if (state != ARM) cnt <= cnt + CW'(1);
          if (cap_amp_cur)  amp_sh <= W'(sample_i);
          if (cap_amp_prev) amp_sh <= W'(prev);
          if (cap_fall) begin
            on_sh <= cnt;
            kf_sh <= W'({prev[W], prev} - {sample_i[W], sample_i});
          end
        end
      end
    end
  end

`ifdef FG_ANALYZER_EDGETIME_EN
  logic [CW-1:0] rise_run, fall_run;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rise_run     <= '0;
      fall_run     <= '0;
      rise_count_o <= '0;
      fall_count_o <= '0;
    end else if (clear_i) begin
      rise_run     <= '0;
      fall_run     <= '0;
      rise_count_o <= '0;
      fall_count_o <= '0;
    end else if (clk_en_i && !abort) begin
      if (rise_start) begin
        if (commit) begin
          rise_count_o <= rise_run;
          fall_count_o <= fall_run;
        end
        rise_run <= '0;
        fall_run <= '0;
      end else begin
        if (state == RISE) rise_run <= rise_run + CW'(1);
        if (state == FALL) fall_run <= fall_run + CW'(1);
      end
    end
  end
`else
  // edge durations are not tracked in this build
`endif

endmodule

// File: tb/tb_fg_waveform_analyzer.sv
// Scoreboard bench for fg_waveform_analyzer: hand-derived expected commits are queued
// as the committing sample is driven and compared when valid_o pulses.
module tb_fg_waveform_analyzer;

  localparam int W  = 16;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic signed [W:0] sample = '0;

  logic [CW-1:0] period, on_count;
  logic [W-1:0]  k_rise, k_fall, amp;
  logic          valid, busy, err;

  logic [3:0]    period4, on4;
  logic [W-1:0]  kr4, kf4, amp4;
  logic          valid4, busy4, err4;

  int n_cmp = 0;
  int n_bad = 0;
  int gap = 0;
  int valid4_cnt = 0;

  typedef struct {
    longint period;
    longint on_count;
    longint k_rise;
    longint k_fall;
    longint amp;
  } result_t;

  result_t exp_q[$];

  fg_waveform_analyzer #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(W)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(en), .clear_i(clr), .sample_i(sample),
    .period_o(period), .on_count_o(on_count), .k_rise_o(k_rise), .k_fall_o(k_fall),
    .amplitude_o(amp), .valid_o(valid), .busy_o(busy), .error_o(err)
  );

  fg_waveform_analyzer #(.COUNTER_BITWIDTH(4), .WAVEFORM_BITWIDTH(W)) dut4 (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(en), .clear_i(clr), .sample_i(sample),
    .period_o(period4), .on_count_o(on4), .k_rise_o(kr4), .k_fall_o(kf4),
    .amplitude_o(amp4), .valid_o(valid4), .busy_o(busy4), .error_o(err4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic put(input int s);
    sample = (W+1)'(s);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_commit(input longint p, input longint o, input longint kr,
                               input longint kf, input longint a);
    result_t e;
    e.period = p; e.on_count = o; e.k_rise = kr; e.k_fall = kf; e.amp = a;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(negedge clk); #1;
    check("pending_commits", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    en = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic trapezoid();
    put(0); put(0);
    for (int i = 0; i < 10; i++) put(100 * (i + 1));
    for (int i = 10; i < 20; i++) put(1000);
    put(800); put(600); put(400); put(200); put(0);
    for (int i = 25; i < 50; i++) put(0);
    expect_commit(50, 20, 100, 200, 1000);
    put(100);
  endtask

  always @(negedge clk) begin
    result_t e;
    if (valid4) valid4_cnt++;
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("period", period, e.period);
        check("on_count", on_count, e.on_count);
        check("k_rise", k_rise, e.k_rise);
        check("k_fall", k_fall, e.k_fall);
        check("amplitude", amp, e.amp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    check("rst_period", period, 0);
    check("rst_amp", amp, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_error", err, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // trapezoid, back-to-back strobes
    gap = 0;
    do_clear();
    trapezoid();
    settle();
    check("trap_error", err, 0);
    check("trap_busy", busy, 1);

    // same trapezoid with idle clocks between strobes
    gap = 3;
    do_clear();
    trapezoid();
    settle();
    gap = 0;

    // triangle
    do_clear();
    put(0); put(300); put(600); put(900); put(700);
    put(500); put(300); put(100); put(0); put(0);
    expect_commit(9, 3, 300, 200, 900);
    put(300);
    settle();

    // retrigger out of FALL, then the next period reveals the 100 rise step
    do_clear();
    put(0); put(500); put(1000); put(1000); put(800); put(600);
    expect_commit(5, 3, 500, 200, 1000);
    put(700);
    settle();
    check("retrig_busy", busy, 1);
    put(700); put(500); put(0);
    expect_commit(4, 2, 100, 200, 700);
    put(100);
    settle();

    // asynchronous reset while in HIGH
    put(100);
    check("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check("arst_period", period, 0);
    check("arst_on_count", on_count, 0);
    check("arst_k_rise", k_rise, 0);
    check("arst_k_fall", k_fall, 0);
    check("arst_amp", amp, 0);
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_error", err, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    put(100);
    check("rearm_wait_busy", busy, 0);
    put(0);
    check("rearm_low_busy", busy, 1);
    put(300); put(300); put(0); put(0);
    expect_commit(4, 2, 300, 300, 300);
    put(300);
    settle();

    // clear zeroes held results
    do_clear();
    check("clr_period", period, 0);
    check("clr_amp", amp, 0);
    check("clr_busy", busy, 0);

    // malformed: rise while in HIGH, then a negative sample
    put(0); put(100); put(100); put(200);
    check("hi_rise_error", err, 1);
    check("hi_rise_busy", busy, 0);
    do_clear();
    check("clr_error", err, 0);
    put(0); put(100);
    put(-5);
    check("neg_error", err, 1);
    check("neg_busy", busy, 0);
    settle();

    // counter saturation on the 4-bit instance
    do_clear();
    valid4_cnt = 0;
    put(0);
    repeat (20) put(500);
    check("sat_error", err4, 1);
    check("sat_busy", busy4, 0);
    check("sat_valid_count", valid4_cnt, 0);
    check("wide_no_error", err, 0);
    check("wide_busy", busy, 1);
    do_clear();
    check("sat_clr_error", err4, 0);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fg_waveform_analyzer.md
# fg_waveform_analyzer

Measures the parameters of a periodic trapezoid, triangle or pulse waveform from a stream of samples. It recovers period, ON time, rise slope, fall slope and amplitude, using the same encoding the function generator uses to produce the waveform. It sits on the loopback and measurement path after the waveform generator or an external capture source. Each completed period is reported with a one-cycle `valid_o` pulse.

## Interface
- `COUNTER_BITWIDTH`, 32, width of the period and ON-time counters
- `WAVEFORM_BITWIDTH`, 16, magnitude width; samples are `WAVEFORM_BITWIDTH+1` bits signed

- `clk_i`  in  1  clock; one clock domain
- `rstn_i`  in  1  reset, asynchronous, active-low
- `clk_en_i`  in  1  sample strobe; the FSM and counters advance only when it is high
- `clear_i`  in  1  synchronous clear; has priority over `clk_en_i`
- `sample_i`  in  `WAVEFORM_BITWIDTH+1`  signed input sample
- `period_o`  out  `COUNTER_BITWIDTH`  strobes between consecutive rise starts
- `on_count_o`  out  `COUNTER_BITWIDTH`  strobes from rise start to the first falling sample
- `k_rise_o`  out  `WAVEFORM_BITWIDTH`  first rising step, `sample - prev`
- `k_fall_o`  out  `WAVEFORM_BITWIDTH`  first falling step, `prev - sample`
- `amplitude_o`  out  `WAVEFORM_BITWIDTH`  peak value
- `valid_o`  out  1  one-clock pulse when the result registers update
- `busy_o`  out  1  high in the `LOW`, `RISE`, `HIGH` and `FALL` states
- `error_o`  out  1  sticky: malformed input or counter saturation

## Operation
- Internal registers:
  - `prev`: last sample
  - `cnt`: strobes since rise start
  - `have_start`
  - shadow captures for k_rise, k_fall, amplitude and on_count
- Rise-start event: a strobe in state `LOW` or `FALL` with `sample_i > prev`.
  - If `have_start` is set: commit the shadows to the outputs, set `period_o = cnt`, pulse `valid_o`.
  - Then set `cnt <= 1`, shadow k_rise `<= sample_i - prev`, `have_start <= 1`, and go to `RISE`.
- States:
  - `ARM`: wait for `sample_i == 0`, then go to `LOW`.
  - `LOW`: zero baseline. A rise start goes to `RISE`.
  - `RISE`:
    - `sample_i > prev`: stay.
    - `sample_i == prev`: go to `HIGH`; amplitude shadow `= sample_i`.
    - `sample_i < prev`: go to `FALL` directly (triangle). Amplitude shadow `= prev`, on_count shadow `= cnt`, k_fall shadow `= prev - sample_i`.
  - `HIGH`:
    - `sample_i == prev`: stay.
    - `sample_i < prev`: go to `FALL`; capture on_count and k_fall as in `RISE`.
    - `sample_i > prev`: error.
  - `FALL`:
    - `sample_i == 0`: go to `LOW`.
    - A rise start retriggers into `RISE`.
- Error: a negative sample in any state sets `error_o`, drops the measurement, clears `have_start` and goes to `ARM`.
- Counting: `cnt` increments on every strobe except a rise start.
- Saturation: if `cnt` would pass all-ones, set `error_o` and go to `ARM` with no commit.
- Arithmetic: differences are computed at `WAVEFORM_BITWIDTH+2` bits and the low `WAVEFORM_BITWIDTH` bits are stored. Legal input is never negative.
- `clear_i`: state `ARM`, `cnt = 0`, `have_start = 0`, `error_o = 0`, all result outputs 0.

## Timing
- Reset: all outputs 0 (including `valid_o`, `busy_o`, `error_o`), state `ARM`, `prev = 0`.
- Result registers update on the clock edge that samples the rise-start strobe.
  - `valid_o` is high for exactly that one following clock cycle, independent of `clk_en_i`.
  - Results hold until the next commit.
- The first commit needs two rise starts; the latency is one full period plus one clock.
- Reset in mid-measurement discards all partial data; the block re-arms on the next zero sample.
- `clk_en_i` low: nothing changes except the `valid_o` deassert.

## Configuration
- `FG_ANALYZER_EDGETIME_EN` defined: adds two outputs, committed with the other results.
  - `rise_count_o` (`COUNTER_BITWIDTH`): strobes spent in `RISE`.
  - `fall_count_o` (`COUNTER_BITWIDTH`): strobes spent in `FALL` until zero or retrigger.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

## Test plan
- Trapezoid, W=16: 0,0; ramp 100..1000 in steps of 100 (index 0–9); 1000 to index 19; 800,600,400,200,0 (index 20–24); 0 to index 49; 100 at index 50. Required: `valid_o`, `period_o=50`, `on_count_o=20`, `k_rise_o=100`, `k_fall_o=200`, `amplitude_o=1000`.
- Triangle: 0,300,600,900,700,500,300,100,0,0,300. Required: `amplitude_o=900`, `on_count_o=3`, `k_fall_o=200`, `period_o=9`.
- Retrigger from `FALL`: 1000 then 800,600, then 700. Required: commit at the 700 sample, `k_rise` shadow `=100`, state `RISE`.
- Saturation with `COUNTER_BITWIDTH=4`: hold 500 for 20 strobes. Required: `error_o=1`, `busy_o=0`, no `valid_o`; `clear_i` then resets `error_o` to 0.
- Trapezoid test with 3 idle clocks (`clk_en_i=0`) between strobes. Required: identical results and a single-clock `valid_o`.
- Assert `rstn_i` during `HIGH`. Required: all outputs 0 immediately; the next commit needs a zero sample followed by two rise starts.
